display_arbiter: RTL and testbench
==================================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter N, default 32, width in bits of the display value (N/4 hex digits); N SHALL be a multiple of 4.
REQ-002 Parameter NREQ, default 4, number of requesters; NREQ SHALL be ≥ 2.
REQ-003 Parameter DWELL_CYCLES, default 100000000, minimum number of clk cycles a granted value is shown; DWELL_CYCLES SHALL be ≥ 1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req  input  NREQ  per-requester display request, level-sensitive.
REQ-007 data  input  NREQ*N  requester i value at bits [i*N+N-1 : i*N].
REQ-008 ack  output  NREQ  one-cycle pulse, one-hot, when requester i is granted and its data is captured.
REQ-009 grant  output  NREQ  one-hot owner of the display, all-zero when idle.
REQ-010 dout  output  N  registered value driving the seven-segment display din.
REQ-011 busy  output  1  high while in state SHOW.

Function
REQ-012 The FSM SHALL have two states: IDLE and SHOW.
REQ-013 Arbitration SHALL be round-robin: search starts at index (ptr+1) mod NREQ, ascending with wrap, and picks the first asserted req bit.
REQ-014 On a grant to index k, the block SHALL, on the same edge, set dout = data[k], grant = one-hot(k), ack = one-hot(k) for exactly one cycle, ptr = k, dwell counter = DWELL_CYCLES-1, and state = SHOW.
REQ-015 Latency: req sampled high on edge t in IDLE -> ack/grant/dout valid after edge t (registered, one cycle).
REQ-016 In IDLE with req all-zero: no state change; dout holds its last value; grant = 0.
REQ-017 In SHOW, while req[k] of the granted k is high, dout SHALL track data[k] every cycle (live update); ack SHALL NOT re-pulse.
REQ-018 In SHOW, if req[k] drops, dout SHALL freeze at its last value; the dwell continues to expiry; grant stays one-hot(k).
REQ-019 In SHOW, the counter SHALL decrement by 1 per cycle; when it is 0, the block re-arbitrates on that edge.
REQ-020 On re-arbitration with any req asserted, REQ-014 applies, including re-grant of k when k is the only requester; the SHOW state is kept with no idle cycle.
REQ-021 On re-arbitration with no req asserted: state = IDLE, grant = 0, dout held.
REQ-022 With DWELL_CYCLES = 1, re-arbitration SHALL occur every cycle.
REQ-023 The counter width SHALL be max(1, clog2(DWELL_CYCLES)) bits; it SHALL never wrap below 0.
REQ-024 Requests arriving during SHOW SHALL NOT pre-empt the current grant; they are served only at dwell expiry.
REQ-025 ack SHALL never assert for an index whose req was low on the granting edge.

Reset
REQ-026 Asserting rst SHALL immediately set: state IDLE, dout = 0, grant = 0, ack = 0, busy = 0, counter = 0, ptr = NREQ-1 (req[0] is first priority after reset).
REQ-027 Reset asserted mid-SHOW SHALL abort the dwell; after release, the block SHALL behave exactly as from power-up.
REQ-028 The first arbitration SHALL occur on the first rising clk edge after rst is deasserted.

Verification (N=32, NREQ=4, DWELL_CYCLES=4)
REQ-029 Reset, req=0: dout=0, grant=0, busy=0 held for 10 cycles; then req[2]=1, data2=0x12345678 -> next cycle ack=0100, grant=0100, dout=0x12345678, busy=1.
REQ-030 req=1111 constant, distinct data: grants SHALL cycle 0,1,2,3,0, each held exactly 4 cycles; ack pulses once per grant.
REQ-031 Only req[1] held, data1 changes 0xA->0xB mid-dwell: dout follows next cycle; at expiry re-grant 1 with ack pulse and no IDLE cycle.
REQ-032 req[3] pulsed for 1 cycle: grant 3 for 4 cycles, dout frozen at the captured value; then IDLE, grant=0, dout retained.
REQ-033 req[0] asserted during SHOW of 2: no pre-emption; grant switches to 0 only after 4 cycles.
REQ-034 rst asserted asynchronously in cycle 2 of a dwell: outputs clear before the next edge; after release with req=1111 the first grant is 0.

Source files
------------

// File: rtl/display_arbiter_if.sv
// Request/grant bundle between display requesters and the display arbiter.
// req is a level request; ack is a one-cycle pulse on the edge that captures the requester's data.
interface display_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] data;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic [N-1:0]      dout;
    logic              busy;

    modport master (output req, output data, input ack, input grant, input dout, input busy);
    modport slave  (input req, input data, output ack, output grant, output dout, output busy);
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one seven-segment display value among NREQ requesters,
// holding each grant for at least DWELL_CYCLES clocks.
module display_arbiter #(
    parameter int N            = 32,
    parameter int NREQ         = 4,
    parameter int DWELL_CYCLES = 100000000
) (
    input  logic               clk,
    input  logic               rst,
    display_arbiter_if.slave   bus,
    output logic               o_dbg_state
);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int PW = $clog2(NREQ);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [PW-1:0] PTR_RST  = PW'(NREQ - 1);

    typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [PW-1:0]   r_ptr, w_ptr_nx;
    logic [N-1:0]    r_dout, w_dout_nx;
    logic [NREQ-1:0] r_grant, w_grant_nx;
    logic [NREQ-1:0] r_ack, w_ack_nx;

    logic [N-1:0]    w_slot [NREQ];
    logic            w_found;
    logic [PW-1:0]   w_pick;
    logic [PW-1:0]   w_idx;
    logic            w_rearb;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_slot[i] = bus.data[i*N +: N];
        end
    end

    // Search starts just after the last owner and wraps, so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = r_ptr;
        for (int j = 1; j <= NREQ; j++) begin
            w_idx = PW'((int'(r_ptr) + j) % NREQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ptr_nx   = r_ptr;
        w_dout_nx  = r_dout;
        w_grant_nx = r_grant;
        w_ack_nx   = '0;
        w_rearb    = (r_state == IDLE) || (r_cnt == '0);
        if (w_rearb) begin
            if (w_found) begin
                w_state_nx = SHOW;
                w_cnt_nx   = CNT_LOAD;
                w_ptr_nx   = w_pick;
                w_dout_nx  = w_slot[w_pick];
                w_grant_nx = NREQ'(1) << w_pick;
                w_ack_nx   = NREQ'(1) << w_pick;
            end else begin
                w_state_nx = IDLE;
                w_grant_nx = '0;
            end
        end else begin
            // Mid-dwell: follow the owner's data live, freeze once its request drops.
            w_cnt_nx = r_cnt - CW'(1);
            if (bus.req[r_ptr]) begin
                w_dout_nx = w_slot[r_ptr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= PTR_RST;
            r_dout  <= '0;
            r_grant <= '0;
            r_ack   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_ptr   <= w_ptr_nx;
            r_dout  <= w_dout_nx;
            r_grant <= w_grant_nx;
            r_ack   <= w_ack_nx;
        end
    end

    assign bus.ack     = r_ack;
    assign bus.grant   = r_grant;
    assign bus.dout    = r_dout;
    assign bus.busy    = (r_state == SHOW);
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_display_arbiter;
    localparam int N     = 32;
    localparam int NREQ  = 4;
    localparam int DWELL = 4;

    logic clk;
    logic rst;
    logic dbg_state;

    display_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

    display_arbiter #(.N(N), .NREQ(NREQ), .DWELL_CYCLES(DWELL)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: owner, how many cycles the owner has been shown, shown value.
    bit              m_busy;
    int              m_owner;
    int              m_last;
    int              m_shown;
    logic [N-1:0]    m_dout;
    logic [NREQ-1:0] m_ack;

    logic [NREQ*N-1:0] cur_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_shown = 0;
        m_dout  = '0;
        m_ack   = '0;
    endtask

    task automatic model_edge(input logic [NREQ-1:0] r, input logic [NREQ*N-1:0] d);
        int pick;
        m_ack = '0;
        if (!m_busy || m_shown == DWELL) begin
            pick = -1;
            for (int j = 1; j <= NREQ; j++) begin
                if (pick < 0 && r[(m_last + j) % NREQ]) pick = (m_last + j) % NREQ;
            end
            if (pick >= 0) begin
                m_busy  = 1'b1;
                m_owner = pick;
                m_last  = pick;
                m_shown = 1;
                m_dout  = d[pick*N +: N];
                m_ack[pick] = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end else begin
            m_shown++;
            if (r[m_owner]) m_dout = d[m_owner*N +: N];
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] exp_grant;
        exp_grant = m_busy ? (NREQ'(1) << m_owner) : '0;
        check("dout",  64'(bus.dout),  64'(m_dout));
        check("grant", 64'(bus.grant), 64'(exp_grant));
        check("ack",   64'(bus.ack),   64'(m_ack));
        check("busy",  64'(bus.busy),  64'(m_busy));
        check("state", 64'(dbg_state), 64'(m_busy));
    endtask

    task automatic step(input logic [NREQ-1:0] r);
        bus.req  = r;
        bus.data = cur_data;
        @(posedge clk);
        model_edge(r, cur_data);
        #1;
        check_outputs();
    endtask

    task automatic set_slot(input int i, input logic [N-1:0] v);
        cur_data[i*N +: N] = v;
    endtask

    initial begin
        logic [NREQ-1:0] rr;
        rst      = 1'b1;
        bus.req  = '0;
        bus.data = '0;
        cur_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_dout",  64'(bus.dout),  64'h0);
        check("rst_grant", 64'(bus.grant), 64'h0);
        check("rst_busy",  64'(bus.busy),  64'h0);
        rst = 1'b0;

        // Idle for 10 cycles, then a lone request on slot 2.
        repeat (10) step('0);
        set_slot(2, 32'h12345678);
        step(4'b0100);
        check("first_ack",  64'(bus.ack),  64'h4);
        check("first_dout", 64'(bus.dout), 64'h12345678);
        check("first_busy", 64'(bus.busy), 64'h1);
        repeat (DWELL + 1) step('0);

        // All requesting: grants rotate, each held DWELL cycles.
        for (int i = 0; i < NREQ; i++) set_slot(i, 32'hC0DE0000 + 32'(i));
        repeat (5 * DWELL) step(4'b1111);
        repeat (DWELL + 1) step('0);

        // Lone requester 1 with live data change, then re-grant without idle.
        set_slot(1, 32'hA);
        step(4'b0010);
        set_slot(1, 32'hB);
        step(4'b0010);
        check("live_dout", 64'(bus.dout), 64'hB);
        repeat (DWELL - 1) step(4'b0010);
        check("regrant_ack",  64'(bus.ack),  64'h2);
        check("regrant_busy", 64'(bus.busy), 64'h1);
        repeat (DWELL) step('0);

        // One-cycle pulse on requester 3: value freezes, then idle with value retained.
        set_slot(3, 32'hFEED0003);
        step(4'b1000);
        set_slot(3, 32'h0BAD0BAD);
        repeat (DWELL) step('0);
        check("pulse_idle_dout", 64'(bus.dout), 64'hFEED0003);

        // No pre-emption: requester 0 arrives while 2 is shown.
        step(4'b0100);
        repeat (DWELL - 1) step(4'b0101);
        check("no_preempt", 64'(bus.grant), 64'h4);
        step(4'b0101);
        check("switch_to_0", 64'(bus.grant), 64'h1);

        // Asynchronous reset in the second cycle of a dwell.
        step(4'b0101);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_dout",  64'(bus.dout),  64'h0);
        check("arst_grant", 64'(bus.grant), 64'h0);
        check("arst_ack",   64'(bus.ack),   64'h0);
        check("arst_busy",  64'(bus.busy),  64'h0);
        @(negedge clk);
        rst = 1'b0;
        step(4'b1111);
        check("post_rst_grant", 64'(bus.grant), 64'h1);

        // Random traffic.
        rr = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) rr = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) == 0) set_slot(i, $urandom);
            end
            step(rr);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
